// File: rtl/mlp_seq_pkg.sv
// Shared types and widths for the MLP load sequencer.
// TIMEOUT_CYCLES only matters when MLP_SEQ_TIMEOUT_EN is defined.
package mlp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L0_IN   = 3'd1,
    S_L0_WT   = 3'd2,
    S_LN_WT   = 3'd3,
    S_DRAIN   = 3'd4,
    S_READOUT = 3'd5
  } state_t;

  localparam int ROW_W        = 4;
  localparam int LAYER_W      = 3;
  localparam int BEAT_W       = 3;
  localparam int RESULT_CNT_W = 7;

  localparam logic LOAD_TYPE_INPUT  = 1'b1;
  localparam logic LOAD_TYPE_WEIGHT = 1'b0;

  localparam int TIMEOUT_CYCLES = 1024;
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

endpackage

// File: rtl/mlp_seq_index_cnt.sv
// Nested beat/row/layer counter. row_en lets layer 0 hold the row across
// its input half so the row only moves after the matching weight half.
module mlp_seq_index_cnt
  import mlp_seq_pkg::*;
#(
  parameter int BEATS  = 8,
  parameter int ROWS   = 16,
  parameter int LAYERS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               row_en,
  input  logic               clear,
  output logic [BEAT_W-1:0]  beat,
  output logic [ROW_W-1:0]   row,
  output logic [LAYER_W-1:0] layer,
  output logic               beat_last,
  output logic               row_last,
  output logic               layer_last
);

  logic [BEAT_W-1:0]  beat_q,  beat_d;
  logic [ROW_W-1:0]   row_q,   row_d;
  logic [LAYER_W-1:0] layer_q, layer_d;

  assign beat_last  = (beat_q  == BEAT_W'(BEATS - 1));
  assign row_last   = (row_q   == ROW_W'(ROWS - 1));
  assign layer_last = (layer_q == LAYER_W'(LAYERS - 1));

  always_comb begin
    beat_d  = beat_q;
    row_d   = row_q;
    layer_d = layer_q;
    if (clear) begin
      beat_d  = '0;
      row_d   = '0;
      layer_d = '0;
    end else if (inc) begin
      if (beat_last) begin
        beat_d = '0;
        if (row_en) begin
          if (row_last) begin
            row_d   = '0;
            layer_d = layer_last ? '0 : layer_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      row_q   <= '0;
      layer_q <= '0;
    end else begin
      beat_q  <= beat_d;
      row_q   <= row_d;
      layer_q <= layer_d;
    end
  end

  assign beat  = beat_q;
  assign row   = row_q;
  assign layer = layer_q;

endmodule

// File: rtl/mlp_load_sequencer.sv
// Sequences one 8-layer inference: host words -> accelerator load beats, then
// forwards the result burst. Optional DRAIN/READOUT watchdog: MLP_SEQ_TIMEOUT_EN.
module mlp_load_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int NUM_LAYERS    = 8,
  parameter int ROWS          = 16,
  parameter int BEATS_PER_ROW = 8,
  parameter int RESULT_BEATS  = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               s_valid_i,
  input  logic [31:0]        s_data_i,
  output logic               s_ready_o,
  output logic               load_en_o,
  output logic [31:0]        load_payload_o,
  output logic               load_type_o,
  output logic [ROW_W-1:0]   input_load_number_o,
  output logic [LAYER_W-1:0] layer_number_o,
  output logic [BEAT_W-1:0]  weight_number_o,
  input  logic               result_valid_i,
  input  logic [31:0]        result_payload_i,
  output logic               m_valid_o,
  output logic [31:0]        m_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   load_en_q, load_en_d;
  logic [31:0]        payload_q, payload_d;
  logic               type_q, type_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [BEAT_W-1:0]  wn_q, wn_d;
  logic               m_valid_q, m_valid_d;
  logic [31:0]        m_data_q, m_data_d;
  logic [RESULT_CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic               cnt_inc, cnt_row_en, cnt_clear;
  logic [BEAT_W-1:0]  idx_beat;
  logic [ROW_W-1:0]   idx_row;
  logic [LAYER_W-1:0] idx_layer;
  logic               beat_last, row_last, layer_last;
  logic               accept, in_result;

`ifdef MLP_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  mlp_seq_index_cnt #(
    .BEATS  (BEATS_PER_ROW),
    .ROWS   (ROWS),
    .LAYERS (NUM_LAYERS)
  ) u_idx (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (cnt_inc),
    .row_en     (cnt_row_en),
    .clear      (cnt_clear),
    .beat       (idx_beat),
    .row        (idx_row),
    .layer      (idx_layer),
    .beat_last  (beat_last),
    .row_last   (row_last),
    .layer_last (layer_last)
  );

  assign s_ready_o = (state_q == S_L0_IN) || (state_q == S_L0_WT) || (state_q == S_LN_WT);
  assign accept    = s_valid_i & s_ready_o;
  assign in_result = (state_q == S_DRAIN) || (state_q == S_READOUT);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_en_d  = 1'b0;
    payload_d  = payload_q;
    type_d     = type_q;
    row_d      = row_q;
    layer_d    = layer_q;
    wn_d       = wn_q;
    m_valid_d  = 1'b0;
    m_data_d   = m_data_q;
    res_cnt_d  = res_cnt_q;
    cnt_inc    = 1'b0;
    cnt_row_en = 1'b0;
    cnt_clear  = 1'b0;
`ifdef MLP_SEQ_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif

    // Load port snapshots the indices of the word being accepted.
    if (accept) begin
      load_en_d  = 1'b1;
      payload_d  = s_data_i;
      type_d     = (state_q == S_L0_IN) ? LOAD_TYPE_INPUT : LOAD_TYPE_WEIGHT;
      row_d      = idx_row;
      layer_d    = idx_layer;
      wn_d       = (state_q == S_L0_IN) ? '0 : idx_beat;
      cnt_inc    = 1'b1;
      cnt_row_en = (state_q != S_L0_IN);
    end

    if (in_result && result_valid_i) begin
      m_valid_d = 1'b1;
      m_data_d  = result_payload_i;
    end

    case (state_q)
      S_IDLE: begin
        // done_q high means a readout just finished; a start in that cycle is ignored.
        if (start_i && !done_q) begin
          state_d   = S_L0_IN;
          busy_d    = 1'b1;
          cnt_clear = 1'b1;
          res_cnt_d = '0;
`ifdef MLP_SEQ_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      S_L0_IN: begin
        if (accept && beat_last) state_d = S_L0_WT;
      end
      S_L0_WT: begin
        if (accept && beat_last) state_d = row_last ? S_LN_WT : S_L0_IN;
      end
      S_LN_WT: begin
        if (accept && beat_last && row_last && layer_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (result_valid_i) begin
          res_cnt_d = RESULT_CNT_W'(1);
          state_d   = S_READOUT;
        end
      end
      S_READOUT: begin
        if (result_valid_i) begin
          if (res_cnt_q == RESULT_CNT_W'(RESULT_BEATS - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            res_cnt_d = res_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MLP_SEQ_TIMEOUT_EN
    // Watchdog restarts on every result beat; expiry abandons the inference.
    if (in_result) begin
      if (result_valid_i) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
`endif

    if (abort_i) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      load_en_d = 1'b0;
      m_valid_d = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clear = 1'b1;
`ifdef MLP_SEQ_TIMEOUT_EN
      tmo_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      load_en_q <= 1'b0;
      payload_q <= '0;
      type_q    <= 1'b0;
      row_q     <= '0;
      layer_q   <= '0;
      wn_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      load_en_q <= load_en_d;
      payload_q <= payload_d;
      type_q    <= type_d;
      row_q     <= row_d;
      layer_q   <= layer_d;
      wn_q      <= wn_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      res_cnt_q <= res_cnt_d;
    end
  end

`ifdef MLP_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign load_en_o           = load_en_q;
  assign load_payload_o      = payload_q;
  assign load_type_o         = type_q;
  assign input_load_number_o = row_q;
  assign layer_number_o      = layer_q;
  assign weight_number_o     = wn_q;
  assign m_valid_o           = m_valid_q;
  assign m_data_o            = m_data_q;

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Scoreboard bench for mlp_load_sequencer: load beats and result beats are
// predicted at drive time and matched against DUT output one cycle later.
module tb_mlp_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, abort_i, s_valid_i, s_ready_o;
  logic [31:0] s_data_i;
  logic        load_en_o, load_type_o;
  logic [31:0] load_payload_o;
  logic [3:0]  input_load_number_o;
  logic [2:0]  layer_number_o, weight_number_o;
  logic        result_valid_i, m_valid_o;
  logic [31:0] result_payload_i, m_data_o;
  logic        busy_o, done_o, err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int run_base = 0;
  int ld_seen = 0;
  int done_cnt = 0;
  bit res_exp_en = 1'b0;
  logic [42:0] ld_q[$];
  logic [31:0] res_q[$];

  always #5 clk = ~clk;

  mlp_load_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_i             (start_i),
    .abort_i             (abort_i),
    .s_valid_i           (s_valid_i),
    .s_data_i            (s_data_i),
    .s_ready_o           (s_ready_o),
    .load_en_o           (load_en_o),
    .load_payload_o      (load_payload_o),
    .load_type_o         (load_type_o),
    .input_load_number_o (input_load_number_o),
    .layer_number_o      (layer_number_o),
    .weight_number_o     (weight_number_o),
    .result_valid_i      (result_valid_i),
    .result_payload_i    (result_payload_i),
    .m_valid_o           (m_valid_o),
    .m_data_o            (m_data_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .err_o               (err_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Word w of an inference -> {payload, type, row, layer, weight_number}.
  function automatic logic [42:0] exp_beat(input int w, input logic [31:0] d);
    int r, row, layer, wn, v;
    logic t;
    if (w < 256) begin
      row   = w / 16;
      r     = w % 16;
      layer = 0;
      t     = (r < 8);
      wn    = t ? 0 : r - 8;
    end else begin
      v     = w - 256;
      layer = 1 + v / 128;
      row   = (v % 128) / 8;
      wn    = v % 8;
      t     = 1'b0;
    end
    return {d, t, row[3:0], layer[2:0], wn[2:0]};
  endfunction

  task automatic monitor();
    logic [42:0] e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (load_en_o) begin
        ld_seen++;
        check_eq("ld_pending", 64'(ld_q.size() != 0), 64'd1);
        if (ld_q.size() != 0) begin
          e = ld_q.pop_front();
          check_eq("ld_beat", 64'({load_payload_o, load_type_o, input_load_number_o,
                                    layer_number_o, weight_number_o}), 64'(e));
        end
      end
      if (m_valid_o) begin
        check_eq("res_pending", 64'(res_q.size() != 0), 64'd1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          check_eq("res_beat", 64'(m_data_o), 64'(r));
        end
      end
      if (done_o) done_cnt++;
      if (rst_n && s_valid_i && s_ready_o && !abort_i) begin
        ld_q.push_back(exp_beat(acc_cnt - run_base, s_data_i));
        acc_cnt++;
      end
      if (rst_n && result_valid_i && res_exp_en) res_q.push_back(result_payload_i);
    end
  endtask

  task automatic start_run();
    run_base = acc_cnt;
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    check_eq("start_busy", 64'(busy_o), 64'd1);
    check_eq("start_ready", 64'(s_ready_o), 64'd1);
  endtask

  task automatic drive_words(input bit toggle, input int n);
    int  cyc = 0;
    bit  ph  = 1'b1;
    while ((acc_cnt - run_base) < n && cyc < 5000) begin
      s_valid_i        = toggle ? ph : 1'b1;
      ph               = ~ph;
      s_data_i         = $urandom;
      result_valid_i   = toggle && (cyc % 37 == 5);
      result_payload_i = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid_i      = 1'b0;
    result_valid_i = 1'b0;
    check_eq("load_words", 64'(acc_cnt - run_base), 64'(n));
  endtask

  task automatic drive_results(input bit gaps, input int base);
    res_exp_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      if (gaps && (i % 5 == 2)) begin
        result_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      result_valid_i   = 1'b1;
      result_payload_i = 32'(base + i);
      @(posedge clk); #1;
    end
    result_valid_i = 1'b0;
    res_exp_en     = 1'b0;
  endtask

  task automatic finish_readout(input int d0);
    check_eq("done_high", 64'(done_o), 64'd1);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check_eq("done_once", 64'(done_cnt - d0), 64'd1);
    check_eq("idle_busy", 64'(busy_o), 64'd0);
    check_eq("start_on_done_ignored", 64'(s_ready_o), 64'd0);
    check_eq("res_q_empty", 64'(res_q.size()), 64'd0);
  endtask

  initial begin
    int ld0, d0;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    s_valid_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
    result_valid_i = 1'b1; result_payload_i = 32'h1234_5678;
    fork monitor(); join_none

    repeat (3) @(posedge clk); #1;
    check_eq("rst_load_en", 64'(load_en_o), 64'd0);
    check_eq("rst_payload", 64'(load_payload_o), 64'd0);
    check_eq("rst_type", 64'(load_type_o), 64'd0);
    check_eq("rst_row", 64'(input_load_number_o), 64'd0);
    check_eq("rst_layer", 64'(layer_number_o), 64'd0);
    check_eq("rst_wn", 64'(weight_number_o), 64'd0);
    check_eq("rst_m_valid", 64'(m_valid_o), 64'd0);
    check_eq("rst_m_data", 64'(m_data_o), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_err", 64'(err_o), 64'd0);
    check_eq("rst_ready", 64'(s_ready_o), 64'd0);

    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check_eq("idle_ready", 64'(s_ready_o), 64'd0);
    check_eq("idle_busy0", 64'(busy_o), 64'd0);
    check_eq("idle_no_load", 64'(load_en_o), 64'd0);
    check_eq("idle_no_result", 64'(m_valid_o), 64'd0);
    s_valid_i = 1'b0; result_valid_i = 1'b0;

    // Run A: valid held high, contiguous results 0..127.
    ld0 = ld_seen;
    start_run();
    drive_words(1'b0, 1152);
    @(posedge clk); #1;
    check_eq("a_beats", 64'(ld_seen - ld0), 64'd1152);
    check_eq("a_drain_ready", 64'(s_ready_o), 64'd0);
    check_eq("a_drain_busy", 64'(busy_o), 64'd1);
    d0 = done_cnt;
    drive_results(1'b0, 0);
    finish_readout(d0);

    // Run B: toggling valid, stray results during load, gapped result burst.
    ld0 = ld_seen;
    start_run();
    drive_words(1'b1, 1152);
    @(posedge clk); #1;
    check_eq("b_beats", 64'(ld_seen - ld0), 64'd1152);
    check_eq("b_drain_ready", 64'(s_ready_o), 64'd0);
    d0 = done_cnt;
    drive_results(1'b1, 1000);
    finish_readout(d0);

    // Run C: abort at layer 0, row 5, with a word offered in the abort cycle.
    start_run();
    drive_words(1'b0, 5 * 16 + 3);
    abort_i = 1'b1; s_valid_i = 1'b1; s_data_i = $urandom;
    @(posedge clk); #1;
    abort_i = 1'b0; s_valid_i = 1'b0;
    check_eq("abort_load_en", 64'(load_en_o), 64'd0);
    check_eq("abort_busy", 64'(busy_o), 64'd0);
    check_eq("abort_ready", 64'(s_ready_o), 64'd0);
    check_eq("abort_done", 64'(done_o), 64'd0);
    check_eq("abort_ld_q", 64'(ld_q.size()), 64'd0);

    // Run D: restart from row 0, then sit in DRAIN without results.
    ld0 = ld_seen;
    start_run();
    drive_words(1'b1, 1152);
    check_eq("d_beats_pre", 64'(ld_q.size() <= 1), 64'd1);
    repeat (1100) @(posedge clk); #1;
    check_eq("d_beats", 64'(ld_seen - ld0), 64'd1152);
`ifdef MLP_SEQ_TIMEOUT_EN
    check_eq("tmo_err", 64'(err_o), 64'd1);
    check_eq("tmo_busy", 64'(busy_o), 64'd0);
    check_eq("tmo_done", 64'(done_cnt), 64'd2);
    start_run();
    check_eq("tmo_err_clr", 64'(err_o), 64'd0);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check_eq("tmo_abort_busy", 64'(busy_o), 64'd0);
`else
    check_eq("wait_err", 64'(err_o), 64'd0);
    check_eq("wait_busy", 64'(busy_o), 64'd1);
    check_eq("wait_ready", 64'(s_ready_o), 64'd0);
    d0 = done_cnt;
    drive_results(1'b0, 32'h0001_0000);
    finish_readout(d0);
`endif

    repeat (3) @(posedge clk); #1;
    check_eq("end_ld_q", 64'(ld_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
